// File: rtl/bit_plane_packer_pkg.sv
// Shared types, defaults and plane-mask helpers for the bit-plane packer.
package img_pkg;

  localparam int unsigned PIXEL_WIDTH_DEF = 8;
  localparam int unsigned PACK_WIDTH_DEF  = 8;
  // Widest plane mask the helper functions handle.
  localparam int unsigned MaxPlanes       = 32;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StEmit,
    StDone
  } state_e;

  // Lowest set bit of mask at index >= from; MaxPlanes when there is none.
  function automatic int unsigned next_set_bit(logic [MaxPlanes-1:0] mask, int unsigned from);
    int unsigned res;
    logic        found;
    res   = MaxPlanes;
    found = 1'b0;
    for (int unsigned i = 0; i < MaxPlanes; i++) begin
      if (!found && mask[i] && (i >= from)) begin
        res   = i;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Highest set bit of mask; 0 for an empty mask.
  function automatic int unsigned highest_set_bit(logic [MaxPlanes-1:0] mask);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < MaxPlanes; i++) begin
      if (mask[i]) res = i;
    end
    return res;
  endfunction

endpackage

// File: rtl/bit_plane_packer_if.sv
// Pixel input stream and plane output stream of the bit-plane packer.
interface bit_plane_packer_if #(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned PACK_WIDTH  = 8
);
  localparam int unsigned IdxW = (PIXEL_WIDTH > 1) ? $clog2(PIXEL_WIDTH) : 1;

  logic [PIXEL_WIDTH-1:0] pix_in;
  logic                   pix_valid;
  logic                   pix_ready;
  logic [PACK_WIDTH-1:0]  plane_word;
  logic [IdxW-1:0]        plane_idx;
  logic                   plane_valid;
  logic                   plane_ready;
  logic                   frame_last;

  // Packer side: sinks pixels, sources plane words.
  modport master (
    input  pix_in, pix_valid, plane_ready,
    output pix_ready, plane_word, plane_idx, plane_valid, frame_last
  );

  // Environment side: sources pixels, sinks plane words.
  modport slave (
    output pix_in, pix_valid, plane_ready,
    input  pix_ready, plane_word, plane_idx, plane_valid, frame_last
  );
endinterface

// File: rtl/bit_plane_packer_plane_buffer.sv
// PIXEL_WIDTH x PACK_WIDTH bit array: one row per plane, one column per pixel slot.
module plane_buffer #(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned PACK_WIDTH  = 8,
  localparam int unsigned SlotW = (PACK_WIDTH > 1) ? $clog2(PACK_WIDTH) : 1,
  localparam int unsigned IdxW  = (PIXEL_WIDTH > 1) ? $clog2(PIXEL_WIDTH) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   wr_en_i,
  input  logic [SlotW-1:0]       wr_slot_i,
  input  logic [PIXEL_WIDTH-1:0] wr_pix_i,
  input  logic [IdxW-1:0]        rd_plane_i,
  // Row as it will be after this edge, so a registered reader sees the pixel being written.
  output logic [PACK_WIDTH-1:0]  rd_word_o
);

  logic [PIXEL_WIDTH-1:0][PACK_WIDTH-1:0] mem_q, mem_d;

  // Next contents: clear wins over a slot write.
  always_comb begin
    mem_d = mem_q;
    if (clr_i) begin
      mem_d = '0;
    end else if (wr_en_i) begin
      for (int p = 0; p < PIXEL_WIDTH; p++) begin
        mem_d[p][wr_slot_i] = wr_pix_i[p];
      end
    end
  end

  assign rd_word_o = mem_d[rd_plane_i];

  // Storage register.
  always_ff @(posedge clk_i) begin
    if (rst_i) mem_q <= '0;
    else       mem_q <= mem_d;
  end

endmodule

// File: rtl/bit_plane_packer.sv
// Slices a frame of pixels into bit planes and streams one packed word per enabled plane.
module bit_plane_packer
  import img_pkg::*;
#(
  parameter int unsigned            PIXEL_WIDTH = PIXEL_WIDTH_DEF,
  parameter int unsigned            PACK_WIDTH  = PACK_WIDTH_DEF,
  parameter int unsigned            NUM_PIXELS  = 64,
  parameter logic [PIXEL_WIDTH-1:0] PLANE_MASK  = '1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  bit_plane_packer_if.master bus,
  output logic               busy,
  output logic               done
);

  localparam int unsigned IdxW  = (PIXEL_WIDTH > 1) ? $clog2(PIXEL_WIDTH) : 1;
  localparam int unsigned SlotW = (PACK_WIDTH > 1) ? $clog2(PACK_WIDTH) : 1;
  localparam int unsigned CntW  = $clog2(NUM_PIXELS + 1);
  localparam logic [MaxPlanes-1:0] MaskExt = MaxPlanes'(PLANE_MASK);
  localparam int unsigned FirstPlane = next_set_bit(MaskExt, 0);
  localparam int unsigned LastPlane  = highest_set_bit(MaskExt);

  if (PLANE_MASK == '0) begin : gen_bad_mask
    $error("PLANE_MASK must enable at least one plane");
  end
  if (NUM_PIXELS < 1) begin : gen_bad_num
    $error("NUM_PIXELS must be at least 1");
  end
  if (PIXEL_WIDTH > MaxPlanes) begin : gen_bad_width
    $error("PIXEL_WIDTH exceeds supported plane count");
  end

  state_e                state_q, state_d;
  logic [SlotW-1:0]      slot_q, slot_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [PACK_WIDTH-1:0] word_q, word_d, rd_word;
  logic pix_ready_q, pix_ready_d, valid_q, valid_d, last_q, last_d;
  logic busy_q, busy_d, done_q, done_d;

  logic pix_xfer, plane_xfer, group_end, last_plane, frame_full, wr_en, clr;

  assign pix_xfer   = bus.pix_valid && pix_ready_q;
  assign plane_xfer = valid_q && bus.plane_ready;
  assign group_end  = (slot_q == SlotW'(PACK_WIDTH - 1)) || (cnt_q == CntW'(NUM_PIXELS - 1));
  assign last_plane = (idx_q == IdxW'(LastPlane));
  assign frame_full = (cnt_q == CntW'(NUM_PIXELS));
  assign wr_en      = (state_q == StCollect) && pix_xfer;
  // Buffer is wiped on frame start and between groups of the same frame.
  assign clr = ((state_q == StIdle) && start) ||
               ((state_q == StEmit) && plane_xfer && last_plane && !frame_full);

  plane_buffer #(
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .PACK_WIDTH  (PACK_WIDTH)
  ) u_plane_buffer (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (clr),
    .wr_en_i    (wr_en),
    .wr_slot_i  (slot_q),
    .wr_pix_i   (bus.pix_in),
    .rd_plane_i (idx_d),
    .rd_word_o  (rd_word)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StCollect;
      StCollect: if (pix_xfer && group_end) state_d = StEmit;
      StEmit:    if (plane_xfer && last_plane) state_d = frame_full ? StDone : StCollect;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Slot and pixel counters; slot restarts at each group boundary.
  always_comb begin
    slot_d = slot_q;
    cnt_d  = cnt_q;
    if ((state_q == StIdle) && start) begin
      slot_d = '0;
      cnt_d  = '0;
    end else if (wr_en) begin
      cnt_d  = cnt_q + 1'b1;
      slot_d = group_end ? '0 : slot_q + 1'b1;
    end else if (clr) begin
      slot_d = '0;
    end
  end

  // Next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    pix_ready_d = (state_d == StCollect);
    valid_d     = (state_d == StEmit);
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StDone);
    if (state_d != StEmit)      idx_d = '0;
    else if (state_q != StEmit) idx_d = IdxW'(FirstPlane);
    else if (plane_xfer)        idx_d = IdxW'(next_set_bit(MaskExt, 32'(idx_q) + 32'd1));
    else                        idx_d = idx_q;
    last_d = valid_d && (idx_d == IdxW'(LastPlane)) && (cnt_d == CntW'(NUM_PIXELS));
  end

  assign word_d = valid_d ? rd_word : '0;

  // Counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      word_q      <= '0;
      pix_ready_q <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      pix_ready_q <= pix_ready_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.pix_ready   = pix_ready_q;
  assign bus.plane_valid = valid_q;
  assign bus.plane_word  = word_q;
  assign bus.plane_idx   = idx_q;
  assign bus.frame_last  = last_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_bit_plane_packer.sv
// Directed bench for bit_plane_packer: three configurations, scoreboard of expected plane words.
module tb_bit_plane_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start [3];
  logic       busy [3];
  logic       done [3];
  logic [7:0] pix_in [3];
  logic       pix_valid [3];
  logic       plane_ready [3];
  logic [7:0] o_word [3];
  logic [2:0] o_idx [3];
  logic       o_valid [3];
  logic       o_last [3];
  logic       o_pix_ready [3];

  bit_plane_packer_if #(.PIXEL_WIDTH(8), .PACK_WIDTH(8)) if_a ();
  bit_plane_packer_if #(.PIXEL_WIDTH(8), .PACK_WIDTH(8)) if_b ();
  bit_plane_packer_if #(.PIXEL_WIDTH(8), .PACK_WIDTH(8)) if_c ();

  bit_plane_packer #(.PIXEL_WIDTH(8), .PACK_WIDTH(8), .NUM_PIXELS(8), .PLANE_MASK(8'hFF)) u_a (
    .clk(clk), .rst(rst), .start(start[0]), .bus(if_a), .busy(busy[0]), .done(done[0])
  );
  bit_plane_packer #(.PIXEL_WIDTH(8), .PACK_WIDTH(8), .NUM_PIXELS(10), .PLANE_MASK(8'hFF)) u_b (
    .clk(clk), .rst(rst), .start(start[1]), .bus(if_b), .busy(busy[1]), .done(done[1])
  );
  bit_plane_packer #(.PIXEL_WIDTH(8), .PACK_WIDTH(8), .NUM_PIXELS(8), .PLANE_MASK(8'h81)) u_c (
    .clk(clk), .rst(rst), .start(start[2]), .bus(if_c), .busy(busy[2]), .done(done[2])
  );

  assign if_a.pix_in = pix_in[0];  assign if_a.pix_valid = pix_valid[0];
  assign if_b.pix_in = pix_in[1];  assign if_b.pix_valid = pix_valid[1];
  assign if_c.pix_in = pix_in[2];  assign if_c.pix_valid = pix_valid[2];
  assign if_a.plane_ready = plane_ready[0];
  assign if_b.plane_ready = plane_ready[1];
  assign if_c.plane_ready = plane_ready[2];
  assign o_word[0] = if_a.plane_word;  assign o_idx[0] = if_a.plane_idx;
  assign o_word[1] = if_b.plane_word;  assign o_idx[1] = if_b.plane_idx;
  assign o_word[2] = if_c.plane_word;  assign o_idx[2] = if_c.plane_idx;
  assign o_valid[0] = if_a.plane_valid;  assign o_last[0] = if_a.frame_last;
  assign o_valid[1] = if_b.plane_valid;  assign o_last[1] = if_b.frame_last;
  assign o_valid[2] = if_c.plane_valid;  assign o_last[2] = if_c.frame_last;
  assign o_pix_ready[0] = if_a.pix_ready;
  assign o_pix_ready[1] = if_b.pix_ready;
  assign o_pix_ready[2] = if_c.pix_ready;

  typedef struct packed {
    logic [1:0] dut;
    logic [7:0] word;
    logic [2:0] idx;
    logic       last;
  } exp_t;

  exp_t       sb [$];
  int         vectors = 0;
  int         miscompares = 0;
  bit         last_xfer [3];
  int         xfer_cnt [3];
  int         done_cnt [3];
  logic [7:0] pix_tbl [16];
  logic [7:0] grp1_words [8];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(int d, logic [7:0] w, logic [2:0] i, logic l);
    exp_t e;
    e.dut  = 2'(d);
    e.word = w;
    e.idx  = i;
    e.last = l;
    sb.push_back(e);
  endtask

  // Words for pixels 0..7 with all planes enabled.
  task automatic push_basic(int d, logic final_grp);
    for (int p = 0; p < 8; p++) push(d, grp1_words[p], 3'(p), final_grp && (p == 7));
  endtask

  // Checks everything visible this cycle, then advances one clock.
  task automatic tick();
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (last_xfer[d]) chk($sformatf("done_after_last%0d", d), 32'(done[d]), 32'd1);
      if (o_valid[d]) chk("pix_ready_low_in_emit", 32'(o_pix_ready[d]), 32'd0);
      if (done[d]) done_cnt[d]++;
      last_xfer[d] = 1'b0;
      if (o_valid[d] && plane_ready[d]) begin
        xfer_cnt[d]++;
        last_xfer[d] = o_last[d];
        chk($sformatf("word_expected%0d", d), 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("word_dut", 32'(d), 32'(e.dut));
          chk($sformatf("plane_word%0d_idx%0d", d, e.idx), 32'(o_word[d]), 32'(e.word));
          chk("plane_idx", 32'(o_idx[d]), 32'(e.idx));
          chk("frame_last", 32'(o_last[d]), 32'(e.last));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(int d);
    chk("rst_pix_ready", 32'(o_pix_ready[d]), 32'd0);
    chk("rst_plane_valid", 32'(o_valid[d]), 32'd0);
    chk("rst_plane_word", 32'(o_word[d]), 32'd0);
    chk("rst_plane_idx", 32'(o_idx[d]), 32'd0);
    chk("rst_frame_last", 32'(o_last[d]), 32'd0);
    chk("rst_busy", 32'(busy[d]), 32'd0);
    chk("rst_done", 32'(done[d]), 32'd0);
  endtask

  task automatic pulse_start(int d);
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
  endtask

  task automatic send(int d, int first, int n);
    int budget;
    for (int i = first; i < first + n; i++) begin
      budget       = 0;
      pix_in[d]    = pix_tbl[i];
      pix_valid[d] = 1'b1;
      while (!o_pix_ready[d] && budget < 40) begin
        tick();
        budget++;
      end
      chk("pix_ready_timeout", 32'(o_pix_ready[d]), 32'd1);
      tick();
    end
    pix_valid[d] = 1'b0;
    pix_in[d]    = '0;
  endtask

  task automatic wait_done(int d);
    int budget;
    budget = 0;
    while (!done[d] && budget < 60) begin
      tick();
      budget++;
    end
    chk("done_timeout", 32'(done[d]), 32'd1);
    tick();
    chk("done_one_cycle", 32'(done[d]), 32'd0);
    chk("idle_after_done", 32'(busy[d]), 32'd0);
  endtask

  task automatic wait_idx(int d, logic [2:0] idx);
    int budget;
    budget = 0;
    while (!(o_valid[d] && o_idx[d] == idx) && budget < 20) begin
      tick();
      budget++;
    end
    chk("reach_plane", 32'(o_idx[d]), 32'(idx));
  endtask

  initial begin
    int done_before;
    grp1_words = '{8'hAA, 8'hCC, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int d = 0; d < 3; d++) begin
      start[d] = 1'b0;  pix_in[d] = '0;  pix_valid[d] = 1'b0;  plane_ready[d] = 1'b1;
      last_xfer[d] = 1'b0;  xfer_cnt[d] = 0;  done_cnt[d] = 0;
    end
    rst = 1'b1;
    repeat (3) tick();
    for (int d = 0; d < 3; d++) chk_reset_vals(d);
    rst = 1'b0;
    tick();

    // Pixels offered while idle are ignored.
    pix_in[0] = 8'hFF;  pix_valid[0] = 1'b1;
    repeat (3) begin
      tick();
      chk("idle_pix_ready", 32'(o_pix_ready[0]), 32'd0);
      chk("idle_busy", 32'(busy[0]), 32'd0);
    end
    pix_valid[0] = 1'b0;  pix_in[0] = '0;

    // Full single-group frame, pixels 0..7.
    for (int i = 0; i < 16; i++) pix_tbl[i] = 8'(i);
    push_basic(0, 1'b1);
    pulse_start(0);
    chk("collect_busy", 32'(busy[0]), 32'd1);
    chk("collect_pix_ready", 32'(o_pix_ready[0]), 32'd1);
    send(0, 0, 8);
    wait_done(0);
    chk("xfer_count_a", 32'(xfer_cnt[0]), 32'd8);

    // Two groups, the second partial.
    push_basic(1, 1'b0);
    for (int p = 0; p < 8; p++)
      push(1, (p == 0) ? 8'h02 : (p == 3) ? 8'h03 : 8'h00, 3'(p), p == 7);
    pulse_start(1);
    send(1, 0, 10);
    wait_done(1);
    chk("xfer_count_b", 32'(xfer_cnt[1]), 32'd16);

    // Backpressure on plane 2.
    xfer_cnt[0] = 0;
    push_basic(0, 1'b1);
    pulse_start(0);
    send(0, 0, 8);
    wait_idx(0, 3'd2);
    plane_ready[0] = 1'b0;
    repeat (3) begin
      chk("stall_word", 32'(o_word[0]), 32'hF0);
      chk("stall_idx", 32'(o_idx[0]), 32'd2);
      chk("stall_valid", 32'(o_valid[0]), 32'd1);
      tick();
    end
    chk("stall_word_end", 32'(o_word[0]), 32'hF0);
    plane_ready[0] = 1'b1;
    wait_done(0);
    chk("xfer_count_stall", 32'(xfer_cnt[0]), 32'd8);

    // Sparse plane mask.
    pix_tbl[0] = 8'hFF;  pix_tbl[1] = 8'h00;  pix_tbl[2] = 8'h80;  pix_tbl[3] = 8'h01;
    for (int i = 4; i < 8; i++) pix_tbl[i] = 8'h00;
    push(2, 8'h09, 3'd0, 1'b0);
    push(2, 8'h05, 3'd7, 1'b1);
    pulse_start(2);
    send(2, 0, 8);
    wait_done(2);
    chk("xfer_count_c", 32'(xfer_cnt[2]), 32'd2);

    // start ignored outside IDLE.
    for (int i = 0; i < 16; i++) pix_tbl[i] = 8'(i);
    done_before = done_cnt[0];
    push_basic(0, 1'b1);
    pulse_start(0);
    send(0, 0, 4);
    pulse_start(0);
    chk("restart_collect_ready", 32'(o_pix_ready[0]), 32'd1);
    send(0, 4, 4);
    pulse_start(0);
    chk("restart_emit_valid", 32'(o_valid[0]), 32'd1);
    wait_done(0);
    chk("single_done", 32'(done_cnt[0] - done_before), 32'd1);

    // Reset while plane 3 is presented.
    for (int p = 0; p < 3; p++) push(0, grp1_words[p], 3'(p), 1'b0);
    pulse_start(0);
    send(0, 0, 8);
    wait_idx(0, 3'd3);
    plane_ready[0] = 1'b0;
    rst = 1'b1;
    tick();
    chk_reset_vals(0);
    rst = 1'b0;
    plane_ready[0] = 1'b1;
    done_before = done_cnt[0];
    repeat (5) begin
      tick();
      chk("no_done_after_abort", 32'(done[0]), 32'd0);
    end
    chk("abort_done_count", 32'(done_cnt[0] - done_before), 32'd0);
    chk("abort_sb_empty", 32'(sb.size()), 32'd0);

    // Fresh frame after abort.
    push_basic(0, 1'b1);
    pulse_start(0);
    send(0, 0, 8);
    wait_done(0);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
